spi_regfile_peripheral: RTL and testbench



---
 rtl/spi_regfile_pkg.sv | 22 ++
 rtl/spi_regfile_peripheral_if.sv | 11 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_regfile_peripheral.sv | 180 ++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file target.
package spi_regfile_pkg;

    // Value of the first frame bit selecting the transfer direction.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Progress of the current frame. FR_DONE is the single clk in which
    // the finished frame is judged.
    typedef enum logic [1:0] {
        FR_IDLE,
        FR_HDR,
        FR_DATA,
        FR_DONE
    } frame_status_e;

    // Total frame length: RW bit, address field, data field.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between the pads (controller side) and the target.
interface spi_regfile_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with a history flop
// providing single-clk rise/fall pulses of the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Shift the raw input through the chain; hist keeps the previous synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~hist;
    assign fall = ~dout & hist;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target in front of NUM_REGS read/write configuration registers.
// Frame: RW, ADDR[ADDR_W-1:0], DATA[DATA_W-1:0], MSB first. Frames are
// judged once after chip select rises; bad frames never touch the bank.
//
// Strobe semantics: wr_strobe[i] is high for exactly the one clk in which
// regs_flat slice i first shows the new value; frame_err is a one-clk pulse
// per discarded frame. Neither has backpressure.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_regfile_peripheral_if.slave      spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err,
    output frame_status_e                frame_state
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int HDR_LEN   = 1 + ADDR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    // Wide enough for both the header latch and the data field.
    localparam int RX_W      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    localparam logic [CNT_W-1:0]  CNT_HDR_M1 = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(HDR_LEN);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_LEN + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    // Synchronised pins
    logic sclk_unused_lvl, sclk_rise, sclk_fall;
    logic copi_s, copi_unused_rise, copi_unused_fall;
    logic ncs_s, ncs_rise, ncs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi.sclk),
        .dout(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(spi.copi),
        .dout(copi_s), .rise(copi_unused_rise), .fall(copi_unused_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(spi.ncs),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Frame datapath state
    logic [CNT_W-1:0]   bit_cnt;
    logic [RX_W-1:0]    rx_sr;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  tx_sr;
    logic               tx_active;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  rd_data;

    frame_status_e      state_q, state_d;
    logic               commit, discard;
    logic               len_ok, addr_ok;
    logic [NUM_REGS-1:0] wr_sel;

    assign len_ok  = (bit_cnt == CNT_FULL);
    assign addr_ok = ({1'b0, addr_q} < NUM_REGS_A);

    // Readback source: selected register, zero for unmapped addresses.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, addr_q} == (ADDR_W + 1)'(i)) rd_data = regs_q[i];
        end
    end

    // Receive shifting, bit counting, header latch and readback shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            rw_q      <= RW_READ;
            addr_q    <= '0;
            tx_sr     <= '0;
            tx_active <= 1'b0;
        end else if (ncs_fall) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            rw_q      <= RW_READ;
            addr_q    <= '0;
            tx_active <= 1'b0;
        end else if (ncs_rise) begin
            tx_active <= 1'b0;
        end else if (!ncs_s) begin
            if (sclk_rise) begin
                rx_sr <= {rx_sr[RX_W-2:0], copi_s};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                // Capture RW+ADDR on the same edge that completes the header.
                if (bit_cnt == CNT_HDR_M1) {rw_q, addr_q} <= {rx_sr[ADDR_W-1:0], copi_s};
            end
            if (sclk_fall && (rw_q == RW_READ)) begin
                if (bit_cnt == CNT_HDR) begin
                    tx_sr     <= rd_data;
                    tx_active <= 1'b1;
                end else if ((bit_cnt > CNT_HDR) && (bit_cnt < CNT_FULL)) begin
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end else if (bit_cnt >= CNT_FULL) begin
                    tx_active <= 1'b0;
                end
            end
        end
    end

    assign spi.cipo    = tx_active & tx_sr[DATA_W-1];
    assign spi.cipo_oe = ~ncs_s;

    // Frame status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FR_IDLE;
        else        state_q <= state_d;
    end

    // Frame status next-state and end-of-frame verdict.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            FR_IDLE: if (ncs_fall) state_d = FR_HDR;
            FR_HDR: begin
                if (ncs_rise)                  state_d = FR_DONE;
                else if (bit_cnt == CNT_HDR)   state_d = FR_DATA;
            end
            FR_DATA: if (ncs_rise) state_d = FR_DONE;
            FR_DONE: begin
                if (len_ok && addr_ok) commit  = (rw_q == RW_WRITE);
                else                   discard = 1'b1;
                state_d = FR_IDLE;
            end
        endcase
    end

    assign frame_state = state_q;

    // One-hot write select for a committed frame.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = commit && ({1'b0, addr_q} == (ADDR_W + 1)'(i));
        end
    end

    // Register bank update with matching strobe and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= wr_sel;
            frame_err <= discard;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) regs_q[i] <= rx_sr[DATA_W-1:0];
            end
        end
    end

    // Flatten the bank for the downstream config logic.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: writes, readback, frame
// errors, reset mid-frame and back-to-back frames.
module tb_spi_regfile_peripheral;
    import spi_regfile_pkg::*;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int HALF     = 8;   // clk cycles per sclk half-period

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_regfile_peripheral_if spi ();
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;
    frame_status_e              frame_state;

    spi_regfile_peripheral #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi.slave),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe),
        .frame_err(frame_err), .frame_state(frame_state)
    );

    // Scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [NUM_REGS-1:0] exp_q[$];
    logic [DATA_W-1:0]   model [NUM_REGS];
    int err_cycles = 0;
    int strobe_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = model[i];
        return r;
    endfunction

    // Every strobe must match the next expected one-hot write.
    always @(negedge clk) begin
        if (frame_err) err_cycles++;
        if (wr_strobe != '0) begin
            strobe_cycles++;
            if (exp_q.size() == 0) check("wr_strobe_spurious", 64'(wr_strobe), 64'd0);
            else                   check("wr_strobe", 64'(wr_strobe), 64'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b, output logic sampled);
        spi.copi = b;
        wait_clk(HALF);
        sampled = spi.cipo;
        spi.sclk = 1'b1;
        wait_clk(HALF);
        spi.sclk = 1'b0;
    endtask

    // Lower ncs and clock out n bits (bits[n-1] first); cipo sampled
    // before each of the last DATA_W rising edges lands in rd.
    task automatic send_bits(input int n, input logic [31:0] bits, output logic [DATA_W-1:0] rd);
        logic s;
        rd = '0;
        spi.ncs = 1'b0;
        wait_clk(HALF);
        check("cipo_oe_on", 64'(spi.cipo_oe), 64'd1);
        for (int i = n - 1; i >= 0; i--) begin
            shift_bit(bits[i], s);
            if (i < DATA_W) rd = {rd[DATA_W-2:0], s};
        end
        wait_clk(HALF);
    endtask

    task automatic end_frame(input int gap);
        spi.ncs = 1'b1;
        wait_clk(gap);
        check("cipo_oe_off", 64'(spi.cipo_oe), 64'd0);
    endtask

    logic [DATA_W-1:0] rd;
    int e0, s0;

    initial begin
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        wait_clk(5);
        check("rst_regs", 64'(regs_flat), 64'd0);
        check("rst_strobe", 64'(wr_strobe), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_cipo", 64'(spi.cipo), 64'd0);
        check("rst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
        check("rst_state", 64'(frame_state), 64'(FR_IDLE));
        rst_n = 1'b1;
        wait_clk(5);

        // Write reg 2 = 0xA5 with latency check (SYNC_STAGES+2 = 4 clk)
        send_bits(16, 32'h82A5, rd);
        exp_q.push_back(5'b00100);
        spi.ncs = 1'b1;
        wait_clk(3);
        check("t1_regs_early", 64'(regs_flat), 64'd0);
        check("t1_state_done", 64'(frame_state), 64'(FR_DONE));
        wait_clk(1);
        model[2] = 8'hA5;
        check("t1_regs", 64'(regs_flat), 64'(model_flat()));
        wait_clk(6);
        check("t1_no_err", 64'(err_cycles), 64'd0);

        // Readback reg 2
        send_bits(16, 32'h0200, rd);
        end_frame(8);
        check("t2_rd_data", 64'(rd), 64'hA5);
        check("t2_regs", 64'(regs_flat), 64'(model_flat()));
        check("t2_no_err", 64'(err_cycles), 64'd0);

        // Out-of-range write: addr 7, data 0xFF
        e0 = err_cycles;
        send_bits(16, 32'h87FF, rd);
        end_frame(8);
        check("t3_err_pulse", 64'(err_cycles - e0), 64'd1);
        check("t3_regs", 64'(regs_flat), 64'(model_flat()));

        // Short frame: 15 bits of write reg1 = 0x5A
        e0 = err_cycles;
        send_bits(15, 32'h40AD, rd);
        end_frame(8);
        check("t4_short_err", 64'(err_cycles - e0), 64'd1);
        check("t4_regs", 64'(regs_flat), 64'(model_flat()));

        // Long frame: write reg1 = 0x5A plus one extra bit
        e0 = err_cycles;
        send_bits(17, 32'h102B4, rd);
        end_frame(8);
        check("t5_long_err", 64'(err_cycles - e0), 64'd1);
        check("t5_regs", 64'(regs_flat), 64'(model_flat()));

        // Out-of-range read: addr 6 returns zeros and is flagged
        e0 = err_cycles;
        send_bits(16, 32'h0600, rd);
        end_frame(8);
        check("t5b_rd_zero", 64'(rd), 64'd0);
        check("t5b_err", 64'(err_cycles - e0), 64'd1);

        // Reset after 9 bits of write reg3 = 0x77
        e0 = err_cycles;
        s0 = strobe_cycles;
        send_bits(9, 32'h106, rd);
        rst_n = 1'b0;
        wait_clk(2);
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        check("t6_rst_regs", 64'(regs_flat), 64'd0);
        check("t6_rst_strobe", 64'(wr_strobe), 64'd0);
        check("t6_rst_err", 64'(frame_err), 64'd0);
        check("t6_rst_cipo", 64'(spi.cipo), 64'd0);
        check("t6_rst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
        spi.ncs = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(8);
        check("t6_no_err", 64'(err_cycles - e0), 64'd0);
        check("t6_no_strobe", 64'(strobe_cycles - s0), 64'd0);
        send_bits(16, 32'h803C, rd);
        exp_q.push_back(5'b00001);
        end_frame(8);
        model[0] = 8'h3C;
        check("t6_write_after", 64'(regs_flat), 64'(model_flat()));

        // Back-to-back writes with 2 clk of ncs high
        e0 = err_cycles;
        s0 = strobe_cycles;
        send_bits(16, 32'h8011, rd);
        exp_q.push_back(5'b00001);
        end_frame(2);
        send_bits(16, 32'h8444, rd);
        exp_q.push_back(5'b10000);
        end_frame(8);
        model[0] = 8'h11;
        model[4] = 8'h44;
        check("t7_regs", 64'(regs_flat), 64'(model_flat()));
        check("t7_strobes", 64'(strobe_cycles - s0), 64'd2);
        check("t7_no_err", 64'(err_cycles - e0), 64'd0);

        check("strobe_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
